// File: rtl/spi_burst_ctrl_if.sv
// rtl/spi_burst_ctrl_if.sv - strobe, shift-register and memory-control bundle for spi_burst_ctrl
interface spi_burst_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              cs;
    logic              sclk_pe;
    logic              sclk_ne;
    logic [ADDR_W:0]   sr_pout;
    logic [ADDR_W-1:0] mem_addr;
    logic              dm_we;
    logic              sr_load;
    logic              miso_oe;
    logic              busy;
    logic              overrun;

    modport master (
        output cs, sclk_pe, sclk_ne, sr_pout,
        input  mem_addr, dm_we, sr_load, miso_oe, busy, overrun
    );

    modport slave (
        input  cs, sclk_pe, sclk_ne, sr_pout,
        output mem_addr, dm_we, sr_load, miso_oe, busy, overrun
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - SPI memory transaction sequencer with address counter; SPI_BURST_EN enables burst auto-increment
module spi_burst_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int BYTE_BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    spi_burst_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(BYTE_BITS + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR_SHIFT, ADDR_LATCH, RD_WAIT, RD_LOAD,
        RD_SHIFT, WR_SHIFT, WR_COMMIT, HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              ovr_q;
    logic              oe_q;
    logic              last_bit;
    logic              cnt_en;
    logic              latch_addr;
    logic              incr_addr;
    logic              set_ovr;
    logic              clr_ovr;
    logic              rd_next;

    assign last_bit = (bit_cnt == CNT_W'(BYTE_BITS - 1));

    // Outputs that are pure decodes of the current state or mirror a register
    assign bus.mem_addr = addr_q;
    assign bus.dm_we    = (state_q == WR_COMMIT);
    assign bus.sr_load  = (state_q == RD_LOAD);
    assign bus.busy     = (state_q != IDLE);
    assign bus.miso_oe  = oe_q;
    assign bus.overrun  = ovr_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state plus datapath strobes; cs high overrides everything, so an edge coincident with it is never counted
    always_comb begin
        state_d    = state_q;
        cnt_en     = 1'b0;
        latch_addr = 1'b0;
        incr_addr  = 1'b0;
        set_ovr    = 1'b0;
        clr_ovr    = 1'b0;
        if (bus.cs) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    clr_ovr = 1'b1;
                    state_d = ADDR_SHIFT;
                end
                ADDR_SHIFT: begin
                    cnt_en = bus.sclk_pe;
                    if (bus.sclk_pe && last_bit) state_d = ADDR_LATCH;
                end
                ADDR_LATCH: begin
                    latch_addr = 1'b1;
                    set_ovr    = bus.sclk_pe;
                    state_d    = bus.sr_pout[0] ? RD_WAIT : WR_SHIFT;
                end
                RD_WAIT: begin
                    set_ovr = bus.sclk_pe;
                    state_d = RD_LOAD;
                end
                RD_LOAD: begin
                    set_ovr = bus.sclk_pe;
                    state_d = RD_SHIFT;
                end
                RD_SHIFT: begin
                    cnt_en = bus.sclk_pe;
                    if (bus.sclk_pe && last_bit) begin
`ifdef SPI_BURST_EN
                        incr_addr = 1'b1;
                        state_d   = RD_WAIT;
`else
                        state_d   = HOLD;
`endif
                    end
                end
                WR_SHIFT: begin
                    cnt_en = bus.sclk_pe;
                    if (bus.sclk_pe && last_bit) state_d = WR_COMMIT;
                end
                WR_COMMIT: begin
                    set_ovr = bus.sclk_pe;
`ifdef SPI_BURST_EN
                    incr_addr = 1'b1;
                    state_d   = WR_SHIFT;
`else
                    state_d   = HOLD;
`endif
                end
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
        rd_next = (state_d == RD_WAIT) || (state_d == RD_LOAD) || (state_d == RD_SHIFT);
    end

    // Bit counter, address counter, sticky overrun and MISO enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            addr_q  <= '0;
            ovr_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            if (bus.cs || clr_ovr)  bit_cnt <= '0;
            else if (cnt_en)        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

            if (latch_addr)         addr_q <= bus.sr_pout[ADDR_W:1];
            else if (incr_addr)     addr_q <= addr_q + 1'b1;

            if (clr_ovr)            ovr_q <= 1'b0;
            else if (set_ovr)       ovr_q <= 1'b1;

            // Enable holds across a burst's RD_WAIT/RD_LOAD and drops on the edge that leaves the read states
            if (!rd_next)                                oe_q <= 1'b0;
            else if (state_q == RD_SHIFT && bus.sclk_ne) oe_q <= 1'b1;
        end
    end
endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Transaction sequencer for the SPI memory slave datapath. Drives the shift register, the data memory and the MISO output enable from conditioned CS and SCLK edge strobes. Owns the 7-bit memory address counter, so a single CS-low frame can read or write a run of consecutive bytes. Replaces the single-byte SPI FSM plus address latch in the top level.

## Interface

Parameters:
- ADDR_W, 7: memory address width; the address byte carries ADDR_W address bits plus 1 R/W bit.
- BYTE_BITS, 8: SCLK bits per byte.

Ports:
- clk  in  1  FPGA clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  conditioned chip select, active-low.
- sclk_pe  in  1  one-clk strobe on SCLK rising edge.
- sclk_ne  in  1  one-clk strobe on SCLK falling edge; drives only miso_oe timing.
- sr_pout  in  8  shift register parallel output.
- mem_addr  out  ADDR_W  data memory address.
- dm_we  out  1  data memory write strobe (one clk).
- sr_load  out  1  shift register parallel-load strobe (one clk).
- miso_oe  out  1  MISO tristate enable.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky: an SCLK rising edge arrived while the block could not accept it.

## Operation

- Reset: state IDLE, bit count 0, mem_addr 0, dm_we/sr_load/miso_oe/busy/overrun 0.
- States: IDLE, ADDR_SHIFT, ADDR_LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, HOLD.
- IDLE: cs low causes ADDR_SHIFT, clears bit count and overrun.
- ADDR_SHIFT: count sclk_pe; on the 8th, go to ADDR_LATCH.
- ADDR_LATCH (1 clk): mem_addr <= sr_pout[7:1]. If sr_pout[0]=1, go to RD_WAIT; else go to WR_SHIFT.
- RD_WAIT (1 clk): memory read data settles. Then RD_LOAD.
- RD_LOAD (1 clk): sr_load=1. Then RD_SHIFT.
- RD_SHIFT: miso_oe=1 from the first sclk_ne after entry until leaving the read states. Count sclk_pe; on the 8th, mem_addr <= mem_addr+1 and go to RD_WAIT (burst).
- WR_SHIFT: count sclk_pe; on the 8th, go to WR_COMMIT.
- WR_COMMIT (1 clk): dm_we=1 with dataIn=sr_pout at current mem_addr. Next cycle mem_addr <= mem_addr+1 and state returns to WR_SHIFT (burst).
- Address arithmetic: modulo 2^ADDR_W; 127+1 wraps to 0 with no flag.
- cs high in any state: next state IDLE, miso_oe drops the same edge.
  - Partial byte discarded; no dm_we for an incomplete write byte.
  - mem_addr keeps its value.
- cs high and sclk_pe in the same cycle: cs wins; the edge is not counted.
- sclk_pe during ADDR_LATCH, RD_WAIT, RD_LOAD or WR_COMMIT: ignored (not counted); overrun <= 1.
- cs low but nothing to do (HOLD, non-burst build only): sclk_pe ignored without setting overrun.

## Timing

- Address byte complete to first read byte loaded: 8th sclk_pe at cycle n, ADDR_LATCH n+1, RD_WAIT n+2, sr_load high at n+3.
- Burst read: 8th sclk_pe at n, sr_load at n+2 with the incremented address.
- Write: 8th data sclk_pe at n, dm_we at n+1, mem_addr increments at n+2.
- Master guarantees ≥4 clk between an 8th sclk_pe and the next SCLK edge; violations set overrun.
- dm_we and sr_load are never high in the same cycle and never high outside their own states.

## Configuration

- SPI_BURST_EN defined: burst behaviour as above. RD_SHIFT returns to RD_WAIT and WR_COMMIT returns to WR_SHIFT, with address auto-increment.
- SPI_BURST_EN undefined: after the first data byte (RD_SHIFT 8th sclk_pe, or WR_COMMIT), go to HOLD. mem_addr does not increment; miso_oe=0 in HOLD; stay until cs high.

## Test plan

- Reset mid-write (reset_n low during WR_SHIFT bit 5) -> all outputs 0, state IDLE, no dm_we pulse, mem_addr 0.
- Write frame: address byte 0x14 (addr 0x0A, W), data 0xA5 -> one dm_we pulse at mem_addr 0x0A, one cycle after the 8th data sclk_pe. With burst, mem_addr becomes 0x0B.
- Read frame: address byte 0x15 (addr 0x0A, R) -> sr_load exactly 3 clk after the 8th sclk_pe; miso_oe high from the next sclk_ne; MISO shifts out memory[0x0A].
- Burst read wrapping: address byte 0xFF (addr 0x7F, R), 16 data clocks -> second sr_load with mem_addr 0x00. Without SPI_BURST_EN: no second sr_load, miso_oe 0 after byte 1.
- CS abort: cs high after 5 data bits of a write -> IDLE next clk, no dm_we, mem_addr unchanged. cs high coincident with sclk_pe -> bit not counted.
- Overrun: sclk_pe injected during RD_WAIT -> overrun=1 and bit count unchanged. overrun clears on the next cs falling edge.
